// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - packs RATIO narrow beats into one wide word with keep/last
// Accumulator fills lanes in order; a completed word moves to the output register when it is free.
module stream_packer #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_valid,
   output logic                         i_ready,
   input  logic [IN_WIDTH-1:0]          i_data,
   input  logic                         i_last,
   output logic                         o_valid,
   input  logic                         o_ready,
   output logic [IN_WIDTH*RATIO-1:0]    o_data,
   output logic [RATIO-1:0]             o_keep,
   output logic                         o_last
);

   localparam int W  = IN_WIDTH * RATIO;
   localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

   typedef enum logic {FILLING, COMPLETE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    acc_data_q, acc_data_d;
   logic [RATIO-1:0] acc_keep_q, acc_keep_d;
   logic            acc_last_q, acc_last_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [RATIO-1:0] out_keep_q, out_keep_d;
   logic            out_last_q, out_last_d;
   logic            out_valid_q, out_valid_d;
   logic            load;
   logic            insert;

   // Ready depends only on registers, so no combinational path from either handshake partner.
   assign i_ready = (state_q != COMPLETE) || !out_valid_q;
   assign load    = (state_q == COMPLETE) && (!out_valid_q || o_ready);
   assign insert  = i_valid && i_ready;

   assign o_valid = out_valid_q;
   assign o_data  = out_data_q;
   assign o_keep  = out_keep_q;
   assign o_last  = out_last_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_data_d  = acc_data_q;
      acc_keep_d  = acc_keep_q;
      acc_last_d  = acc_last_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;

      if (load) begin
         out_data_d  = acc_data_q;
         out_keep_d  = acc_keep_q;
         out_last_d  = acc_last_q;
         out_valid_d = 1'b1;
         state_d     = FILLING;
         cnt_d       = '0;
         acc_data_d  = '0;
         acc_keep_d  = '0;
         acc_last_d  = 1'b0;
      end else if (out_valid_q && o_ready) begin
         out_valid_d = 1'b0;
      end

      // An insert only happens in FILLING or alongside a load, so it always lands on a filling accumulator.
      if (insert) begin
         for (int k = 0; k < RATIO; k++) begin
            if (cnt_d == CW'(k)) begin
               acc_data_d[k*IN_WIDTH +: IN_WIDTH] = i_data;
               acc_keep_d[k]                      = 1'b1;
            end
         end
         if ((cnt_d == CW'(RATIO-1)) || i_last) begin
            state_d    = COMPLETE;
            acc_last_d = i_last;
         end else begin
            cnt_d = cnt_d + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= FILLING;
         cnt_q       <= '0;
         acc_data_q  <= '0;
         acc_keep_q  <= '0;
         acc_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_data_q  <= acc_data_d;
         acc_keep_q  <= acc_keep_d;
         acc_last_q  <= acc_last_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_stream_packer.sv
// tb/tb_stream_packer.sv - directed bench for stream_packer with a beat-grouping reference model
module tb_stream_packer;

   localparam int IW = 8;
   localparam int R  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_valid, i_ready, i_last;
   logic [IW-1:0] i_data;
   logic          o_valid, o_ready, o_last;
   logic [31:0]   o_data;
   logic [3:0]    o_keep;

   always #5 clk = ~clk;

   stream_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_last(i_last),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_keep(o_keep), .o_last(o_last)
   );

   typedef struct packed {
      logic        l;
      logic [3:0]  k;
      logic [31:0] d;
   } word_t;

   word_t       exp_q[$];
   word_t       obs_q[$];
   logic [31:0] part_d;
   int          part_n;
   int          n_pass;
   int          n_total;
   logic        hold_prev;
   word_t       hold_w;

   function automatic word_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
      word_t w;
      w.d = d; w.k = k; w.l = l;
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   // Reference: beats accumulate in order; a word closes at four beats or on a last beat.
   task automatic model_insert(input logic [7:0] b, input logic l);
      part_d = part_d | (32'(b) << (8 * part_n));
      part_n++;
      if (part_n == R || l) begin
         exp_q.push_back(mk(part_d, 4'((1 << part_n) - 1), l));
         part_d = '0;
         part_n = 0;
      end
   endtask

   task automatic model_flush();
      exp_q.delete();
      obs_q.delete();
      part_d    = '0;
      part_n    = 0;
      hold_prev = 1'b0;
   endtask

   task automatic monitor();
      word_t w, e;
      w = mk(o_data, o_keep, o_last);
      if (hold_prev)
         chk("stall_stable", 64'({o_valid, w}), 64'({1'b1, hold_w}));
      if (o_valid && o_ready) begin
         obs_q.push_back(w);
         if (exp_q.size() == 0) chk("word_expected", 64'(exp_q.size()), 64'(1));
         else begin
            e = exp_q.pop_front();
            chk("word", 64'(w), 64'(e));
         end
      end
      hold_prev = o_valid && !o_ready;
      hold_w    = w;
      if (i_valid && i_ready && !reset) model_insert(i_data, i_last);
   endtask

   task automatic sample();
      @(negedge clk);
      monitor();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] b, input logic l, output int waits);
      logic acc;
      acc     = 1'b0;
      waits   = 0;
      i_valid = 1'b1;
      i_data  = b;
      i_last  = l;
      while (!acc && waits < 50) begin
         sample();
         if (i_ready) acc = 1'b1;
         else waits++;
         advance();
      end
      if (!acc) chk("accept_timeout", 64'(waits), 64'(0));
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   task automatic drain();
      logic done;
      done    = 1'b0;
      i_valid = 1'b0;
      o_ready = 1'b1;
      for (int n = 0; n < 40 && !done; n++) begin
         sample();
         done = (exp_q.size() == 0) && !o_valid;
         advance();
      end
      if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic chk_obs(input string name, input int idx, input word_t want);
      if (obs_q.size() > idx) chk(name, 64'(obs_q[idx]), 64'(want));
      else chk({name, "_missing"}, 64'(obs_q.size()), 64'(idx + 1));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_o_valid"}, 64'(o_valid), 64'(0));
      chk({tag, "_o_data"},  64'(o_data),  64'(0));
      chk({tag, "_o_keep"},  64'(o_keep),  64'(0));
      chk({tag, "_o_last"},  64'(o_last),  64'(0));
      chk({tag, "_i_ready"}, 64'(i_ready), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w, wsum;
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      i_last  = 1'b0;
      o_ready = 1'b1;
      model_flush();
      #1 reset = 1'b1;
      #1 chk_reset_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // Full word, latency and single-cycle valid
      send_beat(8'h11, 1'b0, w);
      send_beat(8'h22, 1'b0, w);
      send_beat(8'h33, 1'b0, w);
      send_beat(8'h44, 1'b0, w);
      sample();
      chk("lat_edge1_o_valid", 64'(o_valid), 64'(0));
      advance();
      sample();
      chk("lat_edge2_o_valid", 64'(o_valid), 64'(1));
      chk("lat_edge2_o_data", 64'(o_data), 64'(32'h44332211));
      advance();
      sample();
      chk("one_cycle_o_valid", 64'(o_valid), 64'(0));
      advance();
      drain();
      chk_obs("full_word", 0, mk(32'h44332211, 4'b1111, 1'b0));

      // Short packet
      obs_q.delete();
      send_beat(8'hAA, 1'b0, w);
      send_beat(8'hBB, 1'b1, w);
      drain();
      chk_obs("short_word", 0, mk(32'h0000BBAA, 4'b0011, 1'b1));

      // Backpressure: two words stack up
      obs_q.delete();
      o_ready = 1'b0;
      wsum = 0;
      for (int b = 1; b <= 8; b++) begin
         send_beat(8'(b), 1'b0, w);
         wsum += w;
      end
      chk("bp_no_stall_while_filling", 64'(wsum), 64'(0));
      sample();
      chk("bp_i_ready", 64'(i_ready), 64'(0));
      chk("bp_o_valid", 64'(o_valid), 64'(1));
      chk("bp_o_data", 64'(o_data), 64'(32'h04030201));
      advance();
      sample();
      advance();
      o_ready = 1'b1;
      sample();
      advance();
      sample();
      chk("bp_second_o_data", 64'(o_data), 64'(32'h08070605));
      chk("bp_i_ready_back", 64'(i_ready), 64'(1));
      advance();
      drain();
      chk_obs("bp_word0", 0, mk(32'h04030201, 4'b1111, 1'b0));
      chk_obs("bp_word1", 1, mk(32'h08070605, 4'b1111, 1'b0));

      // Streaming at full rate
      obs_q.delete();
      wsum = 0;
      for (int b = 0; b < 12; b++) begin
         send_beat(8'(b), 1'b0, w);
         wsum += w;
      end
      chk("stream_i_ready_never_low", 64'(wsum), 64'(0));
      drain();
      chk_obs("stream_word0", 0, mk(32'h03020100, 4'b1111, 1'b0));
      chk_obs("stream_word1", 1, mk(32'h07060504, 4'b1111, 1'b0));
      chk_obs("stream_word2", 2, mk(32'h0B0A0908, 4'b1111, 1'b0));

      // Last on the final lane, then a fresh word
      obs_q.delete();
      send_beat(8'h10, 1'b0, w);
      send_beat(8'h11, 1'b0, w);
      send_beat(8'h12, 1'b0, w);
      send_beat(8'h13, 1'b1, w);
      send_beat(8'h20, 1'b1, w);
      drain();
      chk_obs("last_full_word", 0, mk(32'h13121110, 4'b1111, 1'b1));
      chk_obs("after_last_word", 1, mk(32'h00000020, 4'b0001, 1'b1));

      // Asynchronous reset with a held word and a partial word in flight
      o_ready = 1'b0;
      send_beat(8'h99, 1'b0, w);
      send_beat(8'h9A, 1'b1, w);
      sample();
      advance();
      sample();
      chk("held_before_reset", 64'(o_valid), 64'(1));
      advance();
      send_beat(8'h55, 1'b0, w);
      send_beat(8'h66, 1'b0, w);
      #1 reset = 1'b1;
      #1 chk_reset_outputs("async_reset");
      reset = 1'b0;
      model_flush();
      o_ready = 1'b1;
      send_beat(8'h01, 1'b0, w);
      send_beat(8'h02, 1'b0, w);
      send_beat(8'h03, 1'b0, w);
      send_beat(8'h04, 1'b0, w);
      drain();
      chk("post_reset_word_count", 64'(obs_q.size()), 64'(1));
      chk_obs("post_reset_word", 0, mk(32'h04030201, 4'b1111, 1'b0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
